// File: rtl/memory_stage.sv
// Memory stage: latches execute results, runs the data-memory handshake,
// aligns load data and emits one write-back record. Option: MEM_MISALIGN_TRAP_EN.
module memory_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_valid,
    input  logic [31:0] exe_alu_result,
    input  logic [31:0] exe_store_data,
    input  logic        exe_wen,
    input  logic [4:0]  exe_regsrc,
    input  logic        exe_is_load,
    input  logic        exe_is_store,
    input  logic [1:0]  exe_mem_size,
    input  logic        exe_load_unsigned,
    output logic        mem_allowin,
    output logic        dm_req,
    output logic        dm_wr,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        mem_fwd_wen,
    output logic [4:0]  mem_fwd_regsrc,
    output logic        wb_valid,
    output logic        wb_wen,
    output logic [4:0]  wb_regsrc,
    output logic [31:0] wb_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        wb_addr_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        valid_q;
    logic [31:0] alu_q;
    logic [31:0] sd_q;
    logic        wen_q;
    logic [4:0]  rd_q;
    logic        load_q;
    logic        store_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic        wb_valid_q;
    logic        wb_wen_q;
    logic [4:0]  wb_regsrc_q;
    logic [31:0] wb_data_q;
    logic        wb_err_q;

    logic        mem_op_q;
    logic        new_mem;
    logic        err_q;
    logic        new_err;
    logic        done;
    logic        accept;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic misal(input logic [1:0] sz, input logic [1:0] a);
        misal = ((sz == 2'd1) & a[0]) | (sz[1] & (a != 2'b00));
    endfunction

    assign err_q   = mem_op_q & misal(size_q, alu_q[1:0]);
    assign new_err = new_mem & misal(exe_mem_size, exe_alu_result[1:0]);
    assign wb_addr_err = wb_err_q;
`else
    assign err_q   = 1'b0;
    assign new_err = 1'b0;
`endif

    assign mem_op_q = load_q | store_q;
    assign new_mem  = exe_is_load | exe_is_store;

    always_comb begin
        done = 1'b0;
        if (valid_q) begin
            if (!mem_op_q || err_q) begin
                done = 1'b1;
            end else if (store_q) begin
                done = (state_q == S_REQ) & dm_gnt;
            end else begin
                done = (((state_q == S_REQ) & dm_gnt) | (state_q == S_WAIT)) & dm_rvalid;
            end
        end
    end

    assign mem_allowin = !valid_q | done;
    assign accept      = exe_valid & mem_allowin;

    always_comb begin
        state_d = state_q;
        if (accept && new_mem && !new_err) begin
            state_d = S_REQ;
        end else if (done) begin
            state_d = S_IDLE;
        end else if (state_q == S_REQ && dm_gnt && load_q) begin
            state_d = S_WAIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            alu_q   <= '0;
            sd_q    <= '0;
            wen_q   <= 1'b0;
            rd_q    <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                valid_q <= 1'b1;
                alu_q   <= exe_alu_result;
                sd_q    <= exe_store_data;
                wen_q   <= exe_wen;
                rd_q    <= exe_regsrc;
                load_q  <= exe_is_load;
                // both flags set is decoded as a load
                store_q <= exe_is_store & ~exe_is_load;
                size_q  <= exe_mem_size;
                uns_q   <= exe_load_unsigned;
            end else if (done) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign dm_req  = (state_q == S_REQ);
    assign dm_wr   = store_q;
    assign dm_addr = {alu_q[31:2], 2'b00};

    always_comb begin
        dm_wstrb = 4'b1111;
        dm_wdata = sd_q;
        case (size_q)
            2'd0: begin
                dm_wstrb = 4'b0001 << alu_q[1:0];
                dm_wdata = {4{sd_q[7:0]}};
            end
            2'd1: begin
                dm_wstrb = alu_q[1] ? 4'b1100 : 4'b0011;
                dm_wdata = {2{sd_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_q[1:0])
            2'd0:    ld_byte = dm_rdata[7:0];
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = alu_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (size_q)
            2'd0:    ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_data = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q  <= 1'b0;
            wb_wen_q    <= 1'b0;
            wb_regsrc_q <= '0;
            wb_data_q   <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            wb_valid_q <= done;
            if (done) begin
                wb_wen_q    <= wen_q & ~store_q & (rd_q != 5'd0) & ~err_q;
                wb_regsrc_q <= rd_q;
                wb_data_q   <= load_q ? ld_data : alu_q;
                wb_err_q    <= err_q;
            end
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_wen    = wb_wen_q;
    assign wb_regsrc = wb_regsrc_q;
    assign wb_data   = wb_data_q;

    // loads stall dependents in the hazard unit instead of forwarding here
    assign mem_fwd_wen    = valid_q & wen_q & (rd_q != 5'd0) & ~load_q;
    assign mem_fwd_regsrc = rd_q;

`ifndef MEM_MISALIGN_TRAP_EN
    logic unused_err;
    assign unused_err = wb_err_q;
`endif

endmodule
